ib_mul_qs_arb: RTL and testbench

IB_MUL_QS_ARB -- requirements
Module: ib_mul_qs_arb

---
 rtl/ib_mul_qs_pkg.sv | 14 +
 rtl/ib_mul_qs_core.sv | 58 +++++
 rtl/ib_mul_qs_arb.sv | 129 ++++++++++++
 tb/tb_ib_mul_qs_arb.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ib_mul_qs_pkg.sv
// Shared types and defaults for the quarter-square multiplier arbiter.
package ib_mul_qs_pkg;

  localparam int unsigned QS_NREQ_DEF = 4;
  localparam int unsigned QS_W_DEF    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQ1  = 2'd1,
    SQ2  = 2'd2,
    DONE = 2'd3
  } qs_state_t;

endpackage

// File: rtl/ib_mul_qs_core.sv
// Quarter-square datapath: one shared squarer used twice per product.
// Phase 1 squares (a+b), phase 2 squares |a-b| and subtracts.
module ib_mul_qs_core
  import ib_mul_qs_pkg::*;
#(
  parameter int unsigned W = QS_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [W-1:0]     i_a,
  input  logic [W-1:0]     i_b,
  input  logic             i_sq1,
  input  logic             i_sq2,
  output logic [2*W-1:0]   o_c
);

  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [2*W-1:0] acc_q;
  logic [2*W-1:0] res_q;

  logic [W:0]     sum;
  logic [W:0]     diff;
  logic [W:0]     sq_in;
  logic [2*W+1:0] sq;
  logic [2*W-1:0] quarter;

  // Phase-selected operand into the single squarer, then divide by four.
  // (a+b) and |a-b| share parity, so the two floors cancel exactly.
  always_comb begin
    sum     = {1'b0, a_q} + {1'b0, b_q};
    diff    = (a_q >= b_q) ? {1'b0, a_q - b_q} : {1'b0, b_q - a_q};
    sq_in   = i_sq1 ? sum : diff;
    sq      = (2*W+2)'(sq_in) * (2*W+2)'(sq_in);
    quarter = (2*W)'(sq >> 2);
  end

  // Operand capture, accumulator load and final subtract.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      res_q <= '0;
    end else begin
      if (i_load) begin
        a_q <= i_a;
        b_q <= i_b;
      end
      if (i_sq1) acc_q <= quarter;
      if (i_sq2) res_q <= acc_q - quarter;
    end
  end

  assign o_c = res_q;

endmodule

// File: rtl/ib_mul_qs_arb.sv
// Round-robin arbiter in front of a shared quarter-square multiplier.
// Optional operation counter enabled by IB_MUL_QS_ARB_STATS_EN.
module ib_mul_qs_arb
  import ib_mul_qs_pkg::*;
#(
  parameter int unsigned NREQ = QS_NREQ_DEF,
  parameter int unsigned W    = QS_W_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NREQ-1:0]          i_req,
  input  logic [NREQ*W-1:0]        i_a,
  input  logic [NREQ*W-1:0]        i_b,
  output logic [NREQ-1:0]          o_gnt,
  output logic                     o_vld,
  input  logic                     i_rdy,
  output logic [2*W-1:0]           o_c,
  output logic [$clog2(NREQ)-1:0]  o_id,
  output logic [15:0]              o_ops
);

  localparam int unsigned IW = $clog2(NREQ);

  qs_state_t       state_q;
  qs_state_t       state_d;
  logic [IW-1:0]   rr_ptr_q;
  logic [IW-1:0]   cur_id_q;
  logic [IW-1:0]   out_id_q;

  logic            found;
  logic [IW-1:0]   gnt_idx;
  logic [W-1:0]    a_sel;
  logic [W-1:0]    b_sel;
  logic            take;

  // Rotating priority search starting at the pointer; also muxes the winner's operands.
  always_comb begin
    int unsigned cand;
    cand    = 0;
    found   = 1'b0;
    gnt_idx = '0;
    a_sel   = '0;
    b_sel   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = (32'(rr_ptr_q) + i) % NREQ;
      if (!found && i_req[cand]) begin
        found   = 1'b1;
        gnt_idx = IW'(cand);
        a_sel   = i_a[cand*W +: W];
        b_sel   = i_b[cand*W +: W];
      end
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (take) state_d = SQ1;
      SQ1:  state_d = SQ2;
      SQ2:  state_d = DONE;
      DONE: if (i_rdy) state_d = take ? SQ1 : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant and valid outputs; grants are suppressed while reset is held.
  always_comb begin
    take  = 1'b0;
    o_gnt = '0;
    o_vld = (state_q == DONE);
    if (!i_rst && found &&
        ((state_q == IDLE) || ((state_q == DONE) && i_rdy))) begin
      take           = 1'b1;
      o_gnt[gnt_idx] = 1'b1;
    end
  end

  // Round-robin pointer and id bookkeeping; o_id follows the result register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr_ptr_q <= '0;
      cur_id_q <= '0;
      out_id_q <= '0;
    end else begin
      if (take) begin
        cur_id_q <= gnt_idx;
        rr_ptr_q <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
      end
      if (state_q == SQ2) out_id_q <= cur_id_q;
    end
  end

  assign o_id = out_id_q;

  ib_mul_qs_core #(
    .W (W)
  ) u_core (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (take),
    .i_a    (a_sel),
    .i_b    (b_sel),
    .i_sq1  (state_q == SQ1),
    .i_sq2  (state_q == SQ2),
    .o_c    (o_c)
  );

`ifdef IB_MUL_QS_ARB_STATS_EN
  logic [15:0] ops_q;

  // Completed-result counter, wraps naturally at 16 bits.
  always_ff @(posedge i_clk) begin
    if (i_rst)               ops_q <= '0;
    else if (o_vld && i_rdy) ops_q <= ops_q + 16'd1;
  end

  assign o_ops = ops_q;
`else
  assign o_ops = '0;
`endif

endmodule

// File: tb/tb_ib_mul_qs_arb.sv
// Scoreboard bench for ib_mul_qs_arb: grants are predicted from the request
// vector, products from a*b, result timing from the grant cycle.
module tb_ib_mul_qs_arb;

  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = 8;
  localparam int unsigned IW   = $clog2(NREQ);

`ifdef IB_MUL_QS_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic                i_clk = 1'b0;
  logic                i_rst = 1'b1;
  logic [NREQ-1:0]     i_req = '0;
  logic [NREQ*W-1:0]   i_a   = '0;
  logic [NREQ*W-1:0]   i_b   = '0;
  logic [NREQ-1:0]     o_gnt;
  logic                o_vld;
  logic                i_rdy = 1'b1;
  logic [2*W-1:0]      o_c;
  logic [IW-1:0]       o_id;
  logic [15:0]         o_ops;

  ib_mul_qs_arb #(
    .NREQ (NREQ),
    .W    (W)
  ) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_req (i_req),
    .i_a   (i_a),
    .i_b   (i_b),
    .o_gnt (o_gnt),
    .o_vld (o_vld),
    .i_rdy (i_rdy),
    .o_c   (o_c),
    .o_id  (o_id),
    .o_ops (o_ops)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int          id;
    logic [15:0] c;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          gnt_log[$];
  logic [15:0] res_by_id [NREQ];
  logic [15:0] last_c;
  int          cyc      = 0;
  int          rr       = 0;
  logic [15:0] ops_m    = '0;
  bit          post_rst = 1'b0;
  bit          prev_vld = 1'b0;
  bit          prev_xfer = 1'b0;
  logic [15:0] prev_c   = '0;
  logic [IW-1:0] prev_id = '0;
  logic [NREQ-1:0] gnt_seen = '0;

  // Monitor / scoreboard, sampled on the falling edge.
  always @(negedge i_clk) begin
    bit   xfer;
    bit   eligible;
    int   win;
    logic [NREQ-1:0] exp_g;
    logic [W-1:0] a;
    logic [W-1:0] b;
    cyc++;
    if (i_rst) begin
      chk("gnt_in_reset", o_gnt, 0);
      sb.delete();
      rr        = 0;
      ops_m     = '0;
      post_rst  = 1'b1;
      prev_vld  = 1'b0;
      prev_xfer = 1'b0;
      gnt_seen  = '0;
    end else begin
      if (post_rst) begin
        chk("rst_vld", o_vld, 0);
        chk("rst_c",   o_c,   0);
        chk("rst_id",  o_id,  0);
        chk("rst_ops", o_ops, 0);
        post_rst = 1'b0;
      end
      chk("ops", o_ops, STATS ? ops_m : 16'd0);

      if (o_vld) begin
        if (sb.size() == 0) begin
          chk("unexpected_vld", o_vld, 0);
        end else begin
          if (!prev_vld || prev_xfer) chk("latency", cyc, sb[0].due);
          else begin
            chk("hold_c",  o_c,  prev_c);
            chk("hold_id", o_id, prev_id);
          end
          chk("result_c",  o_c,  sb[0].c);
          chk("result_id", o_id, sb[0].id);
        end
      end else if (sb.size() > 0 && cyc >= sb[0].due) begin
        chk("missing_vld", o_vld, 1);
      end

      xfer     = o_vld && i_rdy;
      eligible = (sb.size() == 0) || (xfer && sb.size() == 1);
      win      = -1;
      if (eligible) begin
        for (int i = 0; i < NREQ; i++) begin
          if (i_req[(rr + i) % NREQ]) begin
            win = (rr + i) % NREQ;
            break;
          end
        end
      end
      exp_g = '0;
      if (win >= 0) exp_g[win] = 1'b1;
      chk("gnt", o_gnt, exp_g);

      if (xfer && sb.size() > 0) begin
        last_c = o_c;
        res_by_id[sb[0].id] = o_c;
        void'(sb.pop_front());
        ops_m = ops_m + 16'd1;
      end
      if (win >= 0) begin
        a = i_a[win*W +: W];
        b = i_b[win*W +: W];
        sb.push_back('{id: win, c: 16'(a) * 16'(b), due: cyc + 3});
        gnt_log.push_back(win);
        rr = (win + 1) % NREQ;
      end
      gnt_seen  = o_gnt & i_req;
      prev_vld  = o_vld;
      prev_xfer = xfer;
      prev_c    = o_c;
      prev_id   = o_id;
    end
  end

  bit hold_all = 1'b0;

  task automatic tick();
    @(posedge i_clk);
    #1;
    if (!hold_all) i_req = i_req & ~gnt_seen;
  endtask

  task automatic raise(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
    i_a[k*W +: W] = a;
    i_b[k*W +: W] = b;
    i_req[k]      = 1'b1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || i_req != 0 || o_vld) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("drain_timeout", 0, 1);
  endtask

  task automatic do_reset();
    i_rdy = 1'b0;
    i_rst = 1'b1;
    tick();
    tick();
    i_rst = 1'b0;
    i_rdy = 1'b1;
    tick();
  endtask

  initial begin
    int n;
    int exp_ids [5];
    exp_ids = '{0, 1, 2, 3, 0};

    do_reset();

    // All four requesting with corner operands, requests held.
    gnt_log.delete();
    raise(0, 8'hFF, 8'hFF);
    raise(1, 8'h00, 8'hFF);
    raise(2, 8'h55, 8'h55);
    raise(3, 8'h80, 8'h01);
    hold_all = 1'b1;
    n = 0;
    while (gnt_log.size() < 5 && n < 40) begin
      tick();
      n++;
    end
    hold_all = 1'b0;
    i_req    = '0;
    if (gnt_log.size() < 5) chk("rr_timeout", gnt_log.size(), 5);
    else for (int i = 0; i < 5; i++) chk("rr_order", gnt_log[i], exp_ids[i]);
    wait_drain();
    chk("corner_ff_ff", res_by_id[0], 16'hFE01);
    chk("corner_00_ff", res_by_id[1], 16'h0000);
    chk("corner_55_55", res_by_id[2], 16'h1C39);
    chk("corner_80_01", res_by_id[3], 16'h0080);

    // Single request.
    raise(0, 8'h0C, 8'h0A);
    wait_drain();
    chk("single_c", last_c, 16'h0078);

    // Backpressure: result held, a competing request waits for i_rdy.
    i_rdy = 1'b0;
    raise(1, 8'h3A, 8'hC5);
    n = 0;
    while (!o_vld && n < 20) begin
      tick();
      n++;
    end
    if (!o_vld) chk("bp_vld_timeout", 0, 1);
    raise(3, 8'h11, 8'h22);
    repeat (5) tick();
    i_rdy = 1'b1;
    wait_drain();

    // Reset while in SQ2: operation dropped, pointer back to 0.
    raise(2, 8'h77, 8'h99);
    tick();
    tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    raise(0, 8'h02, 8'h03);
    raise(3, 8'h04, 8'h05);
    gnt_log.delete();
    tick();
    chk("post_rst_gnt0", (gnt_log.size() > 0) ? gnt_log[0] : -1, 0);
    wait_drain();

    // Randomised traffic with random backpressure and request withdrawal.
    for (int c = 0; c < 400; c++) begin
      i_rdy = ($urandom_range(0, 9) < 7);
      for (int k = 0; k < NREQ; k++) begin
        if (!i_req[k] && $urandom_range(0, 9) < 3) begin
          case ($urandom_range(0, 5))
            0:       raise(k, 8'h00, W'($urandom));
            1:       raise(k, 8'hFF, 8'hFF);
            2: begin
              logic [W-1:0] v;
              v = W'($urandom);
              raise(k, v, v);
            end
            default: raise(k, W'($urandom), W'($urandom));
          endcase
        end else if (i_req[k] && $urandom_range(0, 19) == 0) begin
          i_req[k] = 1'b0;
        end
      end
      tick();
    end
    i_rdy = 1'b1;
    i_req = '0;
    wait_drain();

    // Operation counter after a clean reset.
    do_reset();
    for (int t = 0; t < 3; t++) begin
      raise(t, W'($urandom), W'($urandom));
      wait_drain();
    end
    tick();
    chk("ops_final", o_ops, STATS ? 3 : 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
